// File: rtl/fsm_counter_param.sv
// Parametrised up/down sequencing counter with an IDLE/COUNT/PAUSE/DONE controller,
// a skip-to-SKIP_VAL jump and selectable wrap or stop-at-terminal behaviour.
module fsm_counter_param #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255,
  parameter int SKIP_VAL  = 5,
  parameter bit WRAP      = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,        // active-high despite the name
  input  logic             start,
  input  logic             stop,
  input  logic             skip,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             skip_taken,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] LP_SKIP = WIDTH'(SKIP_VAL);
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_skip_taken;
  logic             w_skip_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_busy;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_skip_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_COUNT;
        end else if (load) begin
          w_count_nxt = (load_val > LP_MAX) ? LP_MAX : load_val;
        end
      end
      S_COUNT: begin
        if (stop) begin
          w_state_nxt = S_PAUSE;
        end else if (skip) begin
          w_count_nxt = LP_SKIP;
          w_skip_nxt  = 1'b1;
        end else if (up_down) begin
          if (r_count == LP_MAX) begin
            w_done_nxt = 1'b1;
            if (WRAP) w_count_nxt = '0;
            else      w_state_nxt = S_DONE;
          end else begin
            w_count_nxt = r_count + LP_ONE;
          end
        end else begin
          if (r_count == '0) begin
            w_done_nxt = 1'b1;
            if (WRAP) w_count_nxt = LP_MAX;
            else      w_state_nxt = S_DONE;
          end else begin
            w_count_nxt = r_count - LP_ONE;
          end
        end
      end
      S_PAUSE: begin
        if (start && !stop) w_state_nxt = S_COUNT;
      end
      S_DONE: begin
        // Restart reloads from the end the new direction counts away from.
        if (start) begin
          w_state_nxt = S_COUNT;
          w_count_nxt = up_down ? '0 : LP_MAX;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_skip_taken <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_skip_taken <= w_skip_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= (w_state_nxt == S_COUNT);
    end
  end

  assign count_out  = r_count;
  assign skip_taken = r_skip_taken;
  assign done       = r_done;
  assign busy       = r_busy;
  assign state_out  = r_state;

endmodule

// File: tb/tb_fsm_counter_param.sv
// Bench for fsm_counter_param: a stop-mode and a wrap-mode instance share stimulus;
// directed plan scenarios plus randomized traffic against a behavioural model.
module tb_fsm_counter_param;

  localparam int W    = 8;
  localparam int MAXC = 20;
  localparam int SKV  = 5;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start, stop, skip, up_down, load;
  logic [W-1:0] load_val;

  logic [W-1:0] cnt [2];
  logic         sk  [2];
  logic         dn  [2];
  logic         bz  [2];
  logic [1:0]   st  [2];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fsm_counter_param #(.WIDTH(W), .MAX_COUNT(MAXC), .SKIP_VAL(SKV), .WRAP(1'b0)) u_stop (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .skip(skip), .up_down(up_down),
    .load(load), .load_val(load_val), .count_out(cnt[0]), .skip_taken(sk[0]),
    .done(dn[0]), .busy(bz[0]), .state_out(st[0]));

  fsm_counter_param #(.WIDTH(W), .MAX_COUNT(MAXC), .SKIP_VAL(SKV), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .skip(skip), .up_down(up_down),
    .load(load), .load_val(load_val), .count_out(cnt[1]), .skip_taken(sk[1]),
    .done(dn[1]), .busy(bz[1]), .state_out(st[1]));

  // Reference model: state as 0=IDLE 1=COUNT 2=PAUSE 3=DONE, count as a plain integer.
  typedef struct {
    int st;
    int cnt;
    bit sk;
    bit dn;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t model_reset();
    mdl_t r;
    r.st = 0; r.cnt = 0; r.sk = 1'b0; r.dn = 1'b0;
    return r;
  endfunction

  function automatic mdl_t model_next(mdl_t c, bit wrap);
    mdl_t n;
    int   term;
    int   step;
    n    = c;
    n.sk = 1'b0;
    n.dn = 1'b0;
    term = up_down ? MAXC : 0;
    step = up_down ? 1 : -1;
    case (c.st)
      0: if (start) n.st = 1;
         else if (load) n.cnt = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
      1: if (stop) n.st = 2;
         else if (skip) begin n.cnt = SKV; n.sk = 1'b1; end
         else if (c.cnt == term) begin
           n.dn = 1'b1;
           if (wrap) n.cnt = (c.cnt + step + MAXC + 1) % (MAXC + 1);
           else      n.st  = 3;
         end else n.cnt = c.cnt + step;
      2: if (start && !stop) n.st = 1;
      default: if (start) begin n.st = 1; n.cnt = up_down ? 0 : MAXC; end
    endcase
    return n;
  endfunction

  task automatic drive(input bit s, input bit sp, input bit sk_i, input bit ud,
                       input bit ld, input logic [W-1:0] lv);
    start = s; stop = sp; skip = sk_i; up_down = ud; load = ld; load_val = lv;
  endtask

  // One rising edge; model advances on the same sampled inputs; outputs read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    for (int u = 0; u < 2; u++) m[u] = rstn ? model_reset() : model_next(m[u], u == 1);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    drive(0, 0, 0, 1, 0, '0);
    tick();
    tick();
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int u = 0; u < 2; u++) begin
      tests_run++;
      if ({cnt[u], st[u], sk[u], dn[u], bz[u]} !== {8'd0, 2'b00, 3'b000}) begin
        tests_failed++;
        $display("FAIL reset_state unit%0d: got cnt=%0d st=%b sk=%b dn=%b bz=%b want all 0",
                 u, cnt[u], st[u], sk[u], dn[u], bz[u]);
      end
    end
    tick();
    tests_run++;
    if (cnt[0] !== 8'd0 || st[0] !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_release: got cnt=%0d st=%b want 0/00", cnt[0], st[0]);
    end
  endtask

  task automatic test_count_up();
    do_reset();
    drive(1, 0, 0, 1, 0, '0);
    tick();
    tests_run++;
    if (cnt[0] !== 8'd0 || st[0] !== 2'b01 || bz[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL up_start: got cnt=%0d st=%b bz=%b want 0/01/1", cnt[0], st[0], bz[0]);
    end
    drive(0, 0, 0, 1, 0, '0);
    for (int i = 1; i <= MAXC; i++) begin
      tick();
      tests_run++;
      if (cnt[0] !== 8'(i) || dn[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL up_step %0d: got cnt=%0d dn=%b want %0d/0", i, cnt[0], dn[0], i);
      end
    end
    tick();
    tests_run++;
    if (cnt[0] !== 8'(MAXC) || dn[0] !== 1'b1 || st[0] !== 2'b11 || bz[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL up_terminal: got cnt=%0d dn=%b st=%b bz=%b want 20/1/11/0",
               cnt[0], dn[0], st[0], bz[0]);
    end
    tests_run++;
    if (cnt[1] !== 8'd0 || dn[1] !== 1'b1 || st[1] !== 2'b01) begin
      tests_failed++;
      $display("FAIL up_wrap: got cnt=%0d dn=%b st=%b want 0/1/01", cnt[1], dn[1], st[1]);
    end
    tick();
    tests_run++;
    if (cnt[0] !== 8'(MAXC) || dn[0] !== 1'b0 || st[0] !== 2'b11) begin
      tests_failed++;
      $display("FAIL done_hold: got cnt=%0d dn=%b st=%b want 20/0/11", cnt[0], dn[0], st[0]);
    end
  endtask

  task automatic test_skip();
    int exp_seq [5] = '{5, 6, 5, 5, 5};
    bit sk_seq  [5] = '{1, 0, 1, 1, 1};
    do_reset();
    drive(1, 0, 0, 1, 0, '0);
    tick();
    drive(0, 0, 0, 1, 0, '0);
    repeat (12) tick();
    // one-cycle skip, one plain step, then skip held for three cycles
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, sk_seq[k], 1, 0, '0);
      tick();
      tests_run++;
      if (cnt[0] !== 8'(exp_seq[k]) || sk[0] !== sk_seq[k] || dn[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL skip_seq %0d: got cnt=%0d sk=%b dn=%b want %0d/%b/0",
                 k, cnt[0], sk[0], dn[0], exp_seq[k], sk_seq[k]);
      end
    end
    drive(0, 0, 0, 1, 0, '0);
    tick();
    tests_run++;
    if (cnt[0] !== 8'd6 || sk[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL skip_resume: got cnt=%0d sk=%b want 6/0", cnt[0], sk[0]);
    end
  endtask

  task automatic test_wrap_down();
    int exp_c;
    int prev;
    int ndone = 0;
    do_reset();
    drive(0, 0, 0, 0, 1, 8'd3);
    tick();
    tests_run++;
    if (cnt[1] !== 8'd3 || st[1] !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_load: got cnt=%0d st=%b want 3/00", cnt[1], st[1]);
    end
    drive(1, 0, 0, 0, 0, '0);
    tick();
    drive(0, 0, 0, 0, 0, '0);
    exp_c = 3;
    for (int k = 1; k <= 30; k++) begin
      prev  = exp_c;
      exp_c = (exp_c == 0) ? MAXC : exp_c - 1;
      tick();
      if (dn[1] === 1'b1) ndone++;
      tests_run++;
      if (cnt[1] !== 8'(exp_c) || dn[1] !== (prev == 0) || st[1] !== 2'b01) begin
        tests_failed++;
        $display("FAIL wrap_down %0d: got cnt=%0d dn=%b st=%b want %0d/%b/01",
                 k, cnt[1], dn[1], st[1], exp_c, prev == 0);
      end
    end
    tests_run++;
    if (ndone != 2) begin
      tests_failed++;
      $display("FAIL wrap_done_count: got %0d want 2", ndone);
    end
  endtask

  task automatic test_pause();
    do_reset();
    drive(1, 0, 0, 1, 0, '0);
    tick();
    drive(0, 0, 0, 1, 0, '0);
    repeat (8) tick();
    drive(0, 1, 1, 1, 0, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (cnt[0] !== 8'd8 || st[0] !== 2'b10 || sk[0] !== 1'b0 || bz[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL pause_hold %0d: got cnt=%0d st=%b sk=%b bz=%b want 8/10/0/0",
                 k, cnt[0], st[0], sk[0], bz[0]);
      end
    end
    drive(1, 1, 0, 1, 0, '0);
    tick();
    tests_run++;
    if (st[0] !== 2'b10) begin
      tests_failed++;
      $display("FAIL pause_start_stop: got st=%b want 10", st[0]);
    end
    drive(1, 0, 0, 1, 0, '0);
    tick();
    tests_run++;
    if (cnt[0] !== 8'd8 || st[0] !== 2'b01 || bz[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pause_resume: got cnt=%0d st=%b bz=%b want 8/01/1", cnt[0], st[0], bz[0]);
    end
    drive(0, 0, 0, 1, 0, '0);
    for (int v = 9; v <= 10; v++) begin
      tick();
      tests_run++;
      if (cnt[0] !== 8'(v)) begin
        tests_failed++;
        $display("FAIL pause_continue: got cnt=%0d want %0d", cnt[0], v);
      end
    end
  endtask

  task automatic test_dir_load();
    do_reset();
    drive(1, 0, 0, 1, 0, '0);
    tick();
    drive(0, 0, 0, 1, 0, '0);
    repeat (10) tick();
    drive(0, 0, 0, 0, 0, '0);
    tick();
    tests_run++;
    if (cnt[0] !== 8'd9) begin
      tests_failed++;
      $display("FAIL dir_flip: got cnt=%0d want 9", cnt[0]);
    end
    do_reset();
    drive(1, 0, 0, 1, 1, 8'd7);
    tick();
    tests_run++;
    if (cnt[0] !== 8'd0 || st[0] !== 2'b01) begin
      tests_failed++;
      $display("FAIL start_over_load: got cnt=%0d st=%b want 0/01", cnt[0], st[0]);
    end
    do_reset();
    drive(0, 0, 0, 1, 1, 8'd200);
    tick();
    tests_run++;
    if (cnt[0] !== 8'(MAXC)) begin
      tests_failed++;
      $display("FAIL load_clamp: got cnt=%0d want %0d", cnt[0], MAXC);
    end
    drive(0, 0, 0, 1, 1, 8'd13);
    tick();
    tests_run++;
    if (cnt[0] !== 8'd13) begin
      tests_failed++;
      $display("FAIL load_inrange: got cnt=%0d want 13", cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 0, 0, 1, 0, '0);
    tick();
    drive(0, 0, 0, 1, 0, '0);
    repeat (15) tick();
    #2;
    rstn = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      m[u] = model_reset();
      tests_run++;
      if ({cnt[u], st[u], sk[u], dn[u], bz[u]} !== {8'd0, 2'b00, 3'b000}) begin
        tests_failed++;
        $display("FAIL async_reset unit%0d: got cnt=%0d st=%b sk=%b dn=%b bz=%b want all 0",
                 u, cnt[u], st[u], sk[u], dn[u], bz[u]);
      end
    end
    tick();
    rstn = 1'b0;
    drive(1, 0, 0, 0, 0, '0);
    tick();
    drive(0, 0, 0, 0, 0, '0);
    tick();
    tests_run++;
    if (cnt[0] !== 8'd0 || dn[0] !== 1'b1 || st[0] !== 2'b11) begin
      tests_failed++;
      $display("FAIL down_terminal: got cnt=%0d dn=%b st=%b want 0/1/11", cnt[0], dn[0], st[0]);
    end
    drive(1, 0, 0, 1, 0, '0);
    tick();
    tests_run++;
    if (cnt[0] !== 8'd0 || st[0] !== 2'b01) begin
      tests_failed++;
      $display("FAIL done_reload_up: got cnt=%0d st=%b want 0/01", cnt[0], st[0]);
    end
    drive(0, 0, 0, 1, 0, '0);
    tick();
    tests_run++;
    if (cnt[0] !== 8'd1) begin
      tests_failed++;
      $display("FAIL done_reload_step: got cnt=%0d want 1", cnt[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 800; it++) begin
      rstn = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, W'($urandom_range(0, 40)));
      tick();
      for (int u = 0; u < 2; u++) begin
        tests_run++;
        if ({cnt[u], st[u], sk[u], dn[u], bz[u]} !==
            {W'(m[u].cnt), 2'(m[u].st), m[u].sk, m[u].dn, m[u].st == 1}) begin
          tests_failed++;
          $display("FAIL random it%0d unit%0d: got cnt=%0d st=%b sk=%b dn=%b bz=%b want cnt=%0d st=%0d sk=%b dn=%b bz=%b",
                   it, u, cnt[u], st[u], sk[u], dn[u], bz[u],
                   m[u].cnt, m[u].st, m[u].sk, m[u].dn, m[u].st == 1);
        end
      end
    end
    rstn = 1'b0;
  endtask

  initial begin
    rstn = 1'b1;
    drive(0, 0, 0, 1, 0, '0);
    for (int u = 0; u < 2; u++) m[u] = model_reset();
    test_reset();
    test_count_up();
    test_skip();
    test_wrap_down();
    test_pause();
    test_dir_load();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
